note_player: RTL and testbench
==============================

NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 Parameter TICK_DIV, default 1000: clock cycles per duration tick; legal range 1..65535.
REQ-002 Parameter HP_BASE, default 64: half-period, in clock cycles, of pitch 1.
REQ-003 Parameter HP_STEP, default 8: additional half-period cycles per pitch step.
REQ-004 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port in_valid, input, 1: upstream holds a latched note on in_pitch/in_dur.
REQ-007 Port in_pitch, input, 4: pitch index; 0 = rest (silence).
REQ-008 Port in_dur, input, 4: note length in ticks.
REQ-009 Port in_ready, output, 1: block can accept a note this cycle.
REQ-010 Port audio_out, output, 1: square-wave audio.
REQ-011 Port busy, output, 1: a note is being played or a gap is being inserted.
REQ-012 Port done, output, 1: single-cycle pulse at the end of each note.

Function
REQ-013 States IDLE, PLAY, GAP (GAP exists only per REQ-027); encoding is implementation-defined.
REQ-014 in_ready SHALL be 1 in IDLE and 0 in all other states, driven from a register.
REQ-015 Accept occurs on a rising edge where in_valid=1 and in_ready=1: pitch and duration are registered; state goes IDLE->PLAY.
REQ-016 in_valid while in_ready=0 SHALL be ignored; the upstream must hold the note until it is accepted.
REQ-017 Half-period HP = HP_BASE + (pitch-1)*HP_STEP cycles for pitch 1..15; the counter width must hold HP for pitch 15 without overflow.
REQ-018 PLAY lasts exactly dur*TICK_DIV cycles, counted from the first cycle after accept; the counter must be wide enough for 15*65535.
REQ-019 In the first PLAY cycle audio_out=1 (pitch≠0); it inverts after every HP consecutive cycles; the phase counter restarts on each accept.
REQ-020 Pitch 0: audio_out stays 0 for the whole PLAY period; timing is otherwise identical.
REQ-021 Duration 0: accepted, no PLAY cycles; next cycle is IDLE (or GAP) with done=1 and audio_out=0.
REQ-022 On leaving PLAY: audio_out=0 and done=1 for exactly one cycle, coincident with the first IDLE/GAP cycle.
REQ-023 busy=1 exactly when state≠IDLE.
REQ-024 A new note may be accepted in the same cycle done=1 (back-to-back when GAP is disabled); the next PLAY starts the following cycle.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, in_ready=1, audio_out=0, busy=0, done=0, and clear all counters and the registered note, regardless of clock.
REQ-026 Reset asserted during PLAY aborts the note with no done pulse; after rst_n deasserts, the first rising edge may accept a new note.

Configuration
REQ-027 Macro NOTE_PLAYER_GAP_EN: when defined, after every note the block enters GAP for exactly TICK_DIV cycles (audio_out=0, in_ready=0, busy=1), then IDLE; done pulses on the first GAP cycle. When undefined, GAP does not exist and PLAY goes directly to IDLE.

Verification (TICK_DIV=4, HP_BASE=3, HP_STEP=1, macro undefined unless stated)
REQ-028 Accept pitch=1, dur=2 -> audio_out over the 8 PLAY cycles is 1,1,1,0,0,0,1,1; then 0 with done=1 for one cycle and in_ready=1.
REQ-029 Accept pitch=0, dur=3 -> audio_out=0 and busy=1 for 12 cycles, then done pulse.
REQ-030 Accept dur=0 -> done=1 and busy=0 on the next cycle, audio_out never 1.
REQ-031 Hold in_valid=1 with two notes (pitch=2 dur=1, then pitch=3 dur=1) -> second note accepted on the done cycle; PLAY periods are adjacent; audio_out half-periods are 4 then 5.
REQ-032 Drop rst_n mid-PLAY at cycle 3 of pitch=1, dur=2 -> all outputs immediately at reset values, no done pulse; a new note is accepted after release.
REQ-033 With NOTE_PLAYER_GAP_EN, pitch=1, dur=1 -> 4 PLAY cycles, then 4 GAP cycles (in_ready=0, done on the first), then in_ready=1.

Source files
------------

// File: rtl/note_player.sv
// note_player: square-wave note sequencer; define NOTE_PLAYER_GAP_EN to insert a one-tick GAP after each note
module note_player #(
  parameter int TICK_DIV = 1000,
  parameter int HP_BASE  = 64,
  parameter int HP_STEP  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_pitch,
  input  logic [3:0] in_dur,
  output logic       in_ready,
  output logic       audio_out,
  output logic       busy,
  output logic       done
);
  localparam int CW = 20;
  localparam int HW = $clog2(HP_BASE + 14 * HP_STEP + 1);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`ifdef NOTE_PLAYER_GAP_EN
  localparam state_t POST = GAP;
`else
  localparam state_t POST = IDLE;
`endif
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [HW-1:0] r_ph, w_ph, r_hp;
  logic          r_tone, r_audio, r_done, r_ready;
  logic          w_acc, w_load, w_end, w_wrap, w_audio, w_done;
  assign w_acc     = in_valid & r_ready;
  assign w_load    = (r_state == IDLE) & w_acc;
  assign w_end     = (r_cnt == '0);
  assign w_wrap    = (r_ph == r_hp - HW'(1));
  assign in_ready  = r_ready;
  assign audio_out = r_audio;
  assign done      = r_done;
  assign busy      = (r_state != IDLE);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // next-state: zero-length notes skip PLAY; PLAY/GAP end when the remaining-cycle counter hits zero
  always_comb
    w_next = (r_state == IDLE) ? (w_acc ? (in_dur == 4'd0 ? POST : PLAY) : IDLE) :
             (r_state == PLAY) ? (w_end ? POST : PLAY) :
             (w_end ? IDLE : GAP);
  // next values of counters and registered outputs; r_cnt holds cycles remaining after the current one
  always_comb begin
    w_cnt   = (w_load && in_dur != 4'd0) ? CW'(in_dur) * CW'(TICK_DIV) - CW'(1) :
              (w_next == GAP && r_state != GAP) ? CW'(TICK_DIV - 1) :
              w_end ? '0 : r_cnt - CW'(1);
    w_ph    = (r_state == PLAY && !w_wrap) ? r_ph + HW'(1) : '0;
    w_audio = (w_load && in_dur != 4'd0) ? (in_pitch != 4'd0) :
              (r_state == PLAY && !w_end) ? r_audio ^ (r_tone & w_wrap) : 1'b0;
    w_done  = (r_state == PLAY && w_end) || (w_load && in_dur == 4'd0);
  end
  // datapath and output registers; the note is captured on accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_ph    <= '0;
      r_hp    <= '0;
      r_tone  <= 1'b0;
      r_audio <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_cnt   <= w_cnt;
      r_ph    <= w_ph;
      r_audio <= w_audio;
      r_done  <= w_done;
      r_ready <= (w_next == IDLE);
      if (w_load) begin
        r_hp   <= HW'(HP_BASE + (int'(in_pitch) - 1) * HP_STEP);
        r_tone <= (in_pitch != 4'd0);
      end
    end
endmodule

// File: tb/tb_note_player.sv
// tb_note_player: directed table-driven bench for note_player (TICK_DIV=4, HP_BASE=3, HP_STEP=1)
module tb_note_player;
  localparam int TD = 4;
`ifdef NOTE_PLAYER_GAP_EN
  localparam logic GAP = 1'b1;
`else
  localparam logic GAP = 1'b0;
`endif
  logic clk, rst_n, in_valid, in_ready, audio_out, busy, done;
  logic [3:0] in_pitch, in_dur;
  int tests = 0;
  int fails = 0;

  note_player #(.TICK_DIV(TD), .HP_BASE(3), .HP_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pitch(in_pitch), .in_dur(in_dur),
    .in_ready(in_ready), .audio_out(audio_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pitch;
    logic [3:0]  dur;
    int          n;
    logic [63:0] pat;
  } vec_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(logic [3:0] p, logic [3:0] d);
    in_pitch = p;
    in_dur   = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic play(string tag, int n, logic [63:0] pat);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk($sformatf("%s.audio[%0d]", tag, k), audio_out, pat[n-1-k]);
      chk($sformatf("%s.busy[%0d]", tag, k), busy, 1);
      chk($sformatf("%s.ready[%0d]", tag, k), in_ready, 0);
      chk($sformatf("%s.done[%0d]", tag, k), done, 0);
    end
  endtask

  task automatic end_note(string tag);
    @(negedge clk);
    chk({tag, ".end_done"}, done, 1);
    chk({tag, ".end_audio"}, audio_out, 0);
    chk({tag, ".end_busy"}, busy, GAP);
    chk({tag, ".end_ready"}, in_ready, !GAP);
`ifdef NOTE_PLAYER_GAP_EN
    for (int i = 1; i < TD; i++) begin
      @(negedge clk);
      chk({tag, ".gap_busy"}, busy, 1);
      chk({tag, ".gap_ready"}, in_ready, 0);
      chk({tag, ".gap_done"}, done, 0);
      chk({tag, ".gap_audio"}, audio_out, 0);
    end
    @(negedge clk);
    chk({tag, ".post_ready"}, in_ready, 1);
    chk({tag, ".post_busy"}, busy, 0);
`endif
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'd1,  4'd2, 8,  64'b11100011};
    vecs[1] = '{4'd0,  4'd3, 12, 64'b0};
    vecs[2] = '{4'd5,  4'd0, 0,  64'b0};
    vecs[3] = '{4'd2,  4'd2, 8,  64'b11110000};
    vecs[4] = '{4'd3,  4'd2, 8,  64'b11111000};
    vecs[5] = '{4'd1,  4'd3, 12, 64'b111000111000};
    vecs[6] = '{4'd15, 4'd1, 4,  64'b1111};
    vecs[7] = '{4'd4,  4'd4, 16, 64'b1111110000001111};
    clk = 0; rst_n = 1; in_valid = 0; in_pitch = 0; in_dur = 0;
    #2 rst_n = 0;
    #1;
    chk("rst.ready", in_ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.audio", audio_out, 0);
    chk("rst.done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("idle.ready", in_ready, 1);
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].pitch, vecs[v].dur);
      play($sformatf("v%0d", v), vecs[v].n, vecs[v].pat);
      end_note($sformatf("v%0d", v));
      @(negedge clk);
      chk($sformatf("v%0d.after_done", v), done, 0);
      chk($sformatf("v%0d.after_ready", v), in_ready, 1);
      chk($sformatf("v%0d.after_busy", v), busy, 0);
    end
    // back-to-back: in_valid held, second note taken on the done cycle
    in_pitch = 4'd2; in_dur = 4'd2; in_valid = 1'b1;
    @(posedge clk);
    #1 in_pitch = 4'd3; in_dur = 4'd2;
    play("b2b1", 8, 64'b11110000);
    end_note("b2b1");
    @(posedge clk);
    #1 in_valid = 1'b0;
    play("b2b2", 8, 64'b11111000);
    end_note("b2b2");
    @(negedge clk);
    chk("b2b.after_done", done, 0);
    // reset in the middle of a note
    send(4'd1, 4'd2);
    play("mid", 3, 64'b111);
    #2 rst_n = 0;
    #1;
    chk("midrst.ready", in_ready, 1);
    chk("midrst.busy", busy, 0);
    chk("midrst.audio", audio_out, 0);
    chk("midrst.done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst.hold_done", done, 0);
      chk("midrst.hold_busy", busy, 0);
    end
    rst_n = 1;
    @(negedge clk);
    send(4'd2, 4'd1);
    play("postrst", 4, 64'b1111);
    end_note("postrst");
    @(negedge clk);
    chk("postrst.after_done", done, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
